uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Byte buffer and launch sequencer upstream of uart_top's transmit side.
//   - Accepts bytes on a valid/ready stream and stores them in a DEPTH-entry FIFO.
//   - Drains the FIFO one byte at a time: pulses uart_wr_en for one cycle only while uart_busy is low.
//   - Frees software/host logic from polling busy between frames.
// PARAMETERS
//   DEPTH         16  FIFO entries; power of two, >= 2; AW = $clog2(DEPTH) derived locally
//   GAP_CYCLES    0   idle clk cycles inserted after busy falls, before next launch (0..255)
//   BUSY_TIMEOUT  16  cycles to wait for uart_busy to rise after a launch before giving up (>= 2)
// PORTS
//   clk           in   1     system clock; all logic on posedge
//   rst           in   1     synchronous reset, active-high
//   s_data        in   8     byte to enqueue
//   s_valid       in   1     s_data valid
//   s_ready       out  1     FIFO can accept; equals !full
//   uart_wr_en    out  1     one-cycle launch strobe to uart_top.wr_en
//   uart_data_in  out  8     byte to uart_top.data_in; held stable between launches
//   uart_busy     in   1     uart_top.busy
//   level         out  AW+1  current FIFO occupancy, 0..DEPTH
//   empty         out  1     level == 0
//   full          out  1     level == DEPTH
//   timeout       out  1     one-cycle pulse: busy never rose within BUSY_TIMEOUT
// BEHAVIOUR
//   Reset values: s_ready=1, uart_wr_en=0, uart_data_in=8'h00, level=0, empty=1, full=0, timeout=0.
//     Rd/wr pointers=0, FSM=IDLE, gap/timeout counters=0.
//   Push: s_valid && s_ready at posedge writes mem[wr_ptr]; wr_ptr wraps DEPTH-1 -> 0.
//     s_valid while full: no transfer; data is held by the sender, not dropped.
//   Pop: occurs only in the IDLE launch cycle below; rd_ptr wraps DEPTH-1 -> 0.
//   Push and pop in the same cycle: level unchanged; both pointers advance.
//   FIFO is non-FWFT internally. Flags come from registered level.
//     A byte pushed into an empty FIFO at edge N is launchable at edge N+1.
//   FSM states:
//     IDLE       If !empty && !uart_busy: uart_wr_en<=1, uart_data_in<=mem[rd_ptr], pop, -> WAIT_BUSY.
//     WAIT_BUSY  uart_wr_en<=0.
//                - uart_busy==1 -> WAIT_DONE.
//                - BUSY_TIMEOUT cycles without busy: timeout pulse, -> IDLE. The byte is not re-sent.
//     WAIT_DONE  uart_busy==0 -> GAP (GAP_CYCLES>0, counter loaded with GAP_CYCLES-1), else -> IDLE.
//     GAP        Counter decrements each cycle; at 0 -> IDLE.
//   uart_wr_en is never high on two consecutive cycles.
//   uart_wr_en is never asserted while uart_busy is high.
//   Launch latency: byte written to an empty FIFO at edge N, uart idle -> uart_wr_en high after edge N+1.
//   uart_data_in changes only on a launch edge.
//   Reset mid-frame: FIFO contents are discarded and FSM -> IDLE.
//     An in-flight uart_top frame is not aborted; a new launch waits for uart_busy low.
// CONFIGURATION
//   UART_TX_FIFO_STATS_EN defined:
//     - Adds output frames_sent [15:0]: increments on every launch, wraps 16'hFFFF -> 0.
//     - Adds output timeouts [7:0]: increments on each timeout pulse, saturates at 8'hFF.
//     - Both reset to 0.
//   UART_TX_FIFO_STATS_EN undefined: neither port nor counter exists; all other behaviour is identical.
// TESTING
//   Loopback bench: uart_top tx->rx, 100 MHz clk, rst high 2 cycles.
//   1. Push 8'hAB into empty FIFO -> uart_wr_en high after the next edge with uart_data_in=AB.
//      uart_top later reports rdy with data_out=AB.
//   2. Burst-push AB,55,00,FF back-to-back -> four launches only in IDLE with busy low.
//      Received in order AB,55,00,FF; level returns to 0.
//   3. Push DEPTH+1 bytes while uart is busy -> full=1, s_ready=0 after DEPTH pushes.
//      The extra byte is accepted only after the first pop; no byte is lost.
//   4. Tie uart_busy=0 (uart disconnected), push 8'h3C.
//      -> timeout pulse exactly BUSY_TIMEOUT cycles after the launch; FSM returns to IDLE.
//   5. GAP_CYCLES=4, two bytes queued -> exactly 4 idle cycles between busy falling and the second uart_wr_en.
//   6. Assert rst mid-frame with 3 bytes queued -> level=0, no further uart_wr_en.
//      With STATS_EN: frames_sent=0 after reset.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-entry byte FIFO feeding uart_top, launching one byte per frame while busy is low.
// Optional build macro UART_TX_FIFO_STATS_EN adds the frames_sent and timeouts counter outputs.
module uart_tx_fifo #(
    parameter int  DEPTH        = 16,
    parameter int  GAP_CYCLES   = 0,
    parameter int  BUSY_TIMEOUT = 16,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          uart_wr_en,
    output logic [7:0]    uart_data_in,
    input  logic          uart_busy,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full,
    output logic          timeout
`ifdef UART_TX_FIFO_STATS_EN
    ,
    output logic [15:0]   frames_sent,
    output logic [7:0]    timeouts
`endif
);

    localparam int            TW         = $clog2(BUSY_TIMEOUT);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ZERO = (AW+1)'(0);
    localparam logic [TW-1:0] TMO_LAST   = TW'(BUSY_TIMEOUT - 1);
    localparam logic [7:0]    GAP_LOAD   = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic            s_ready_q, s_ready_d;
    logic            uart_wr_en_q, uart_wr_en_d;
    logic [7:0]      uart_data_in_q, uart_data_in_d;
    logic            timeout_q, timeout_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic            push_s;
    logic            pop_s;

    // Launch sequencer: pops only from IDLE, then tracks the uart frame it started.
    always_comb begin
        state_d        = state_q;
        pop_s          = 1'b0;
        uart_wr_en_d   = 1'b0;
        uart_data_in_d = uart_data_in_q;
        timeout_d      = 1'b0;
        tmo_cnt_d      = tmo_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && !uart_busy) begin
                    pop_s          = 1'b1;
                    uart_wr_en_d   = 1'b1;
                    uart_data_in_d = mem_q[rd_ptr_q];
                    tmo_cnt_d      = '0;
                    state_d        = ST_WAIT_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // The byte is abandoned; the uart never acknowledged it.
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: flags are derived from the next level so they come straight from flops.
    always_comb begin
        push_s   = s_valid && s_ready_q;
        mem_d    = mem_q;
        mem_d[wr_ptr_q] = push_s ? s_data : mem_q[wr_ptr_q];
        wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        level_d  = level_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
        empty_d  = (level_d == LEVEL_ZERO);
        full_d   = (level_d == LEVEL_FULL);
        s_ready_d = !full_d;
    end

    // Storage array; contents are not reset, the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            s_ready_q      <= 1'b1;
            uart_wr_en_q   <= 1'b0;
            uart_data_in_q <= 8'h00;
            timeout_q      <= 1'b0;
            tmo_cnt_q      <= '0;
            gap_cnt_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            s_ready_q      <= s_ready_d;
            uart_wr_en_q   <= uart_wr_en_d;
            uart_data_in_q <= uart_data_in_d;
            timeout_q      <= timeout_d;
            tmo_cnt_q      <= tmo_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign uart_wr_en   = uart_wr_en_q;
    assign uart_data_in = uart_data_in_q;
    assign level        = level_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign timeout      = timeout_q;

`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0] frames_sent_q, frames_sent_d;
    logic [7:0]  timeouts_q, timeouts_d;

    // Frame counter wraps; timeout counter saturates so a stuck link stays visible.
    always_comb begin
        frames_sent_d = frames_sent_q;
        timeouts_d    = timeouts_q;
        if (pop_s) begin
            frames_sent_d = frames_sent_q + 16'd1;
        end else begin
            frames_sent_d = frames_sent_q;
        end
        if (timeout_d && (timeouts_q != 8'hFF)) begin
            timeouts_d = timeouts_q + 8'd1;
        end else begin
            timeouts_d = timeouts_q;
        end
    end

    // Statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_sent_q <= 16'd0;
            timeouts_q    <= 8'd0;
        end else begin
            frames_sent_q <= frames_sent_d;
            timeouts_q    <= timeouts_d;
        end
    end

    assign frames_sent = frames_sent_q;
    assign timeouts    = timeouts_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue/timestamp reference model, directed scenarios, random traffic.
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam int TMO   = 6;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          uart_wr_en;
    logic [7:0]    uart_data_in;
    logic          uart_busy = 1'b0;
    logic [AW:0]   level;
    logic          empty;
    logic          full;
    logic          timeout;
`ifdef UART_TX_FIFO_STATS_EN
    logic [15:0]   frames_sent;
    logic [7:0]    timeouts;
`endif

    uart_tx_fifo #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .uart_wr_en(uart_wr_en), .uart_data_in(uart_data_in), .uart_busy(uart_busy),
        .level(level), .empty(empty), .full(full), .timeout(timeout)
`ifdef UART_TX_FIFO_STATS_EN
        , .frames_sent(frames_sent), .timeouts(timeouts)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a byte queue plus the edge times that gate the next launch.
    logic [7:0] mq[$];
    int         n = 0;
    int         launch_n = 0;
    int         ready_at = 0;
    bit         awaiting = 1'b0;
    bit         in_frame = 1'b0;
    logic [7:0] exp_data = 8'h00;
    bit         exp_wr = 1'b0;
    bit         exp_to = 1'b0;
    int         exp_frames = 0;
    int         exp_tos = 0;

    // Simple uart responder driving uart_busy.
    bit alive = 1'b1;
    bit hold = 1'b0;
    int dly_min = 0, dly_max = 0, len_min = 4, len_max = 4;
    bit armed = 1'b0;
    int pend = 0, plen = 0, busy_left = 0;

    logic [7:0] got[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int size0;
        n++;
        if (rst) begin
            mq.delete();
            awaiting   = 1'b0;
            in_frame   = 1'b0;
            ready_at   = 0;
            exp_data   = 8'h00;
            exp_wr     = 1'b0;
            exp_to     = 1'b0;
            exp_frames = 0;
            exp_tos    = 0;
        end else begin
            size0  = mq.size();
            exp_wr = 1'b0;
            exp_to = 1'b0;
            if (awaiting) begin
                if (uart_busy) begin
                    awaiting = 1'b0;
                    in_frame = 1'b1;
                end else if (n - launch_n == TMO) begin
                    awaiting = 1'b0;
                    exp_to   = 1'b1;
                    ready_at = n + 1;
                    if (exp_tos < 255) exp_tos++;
                end
            end else if (in_frame) begin
                if (!uart_busy) begin
                    in_frame = 1'b0;
                    ready_at = n + 1 + GAP;
                end
            end else if (n >= ready_at && size0 > 0 && !uart_busy) begin
                exp_data   = mq.pop_front();
                exp_wr     = 1'b1;
                awaiting   = 1'b1;
                launch_n   = n;
                exp_frames = (exp_frames + 1) % 65536;
            end
            if (s_valid && size0 < DEPTH) mq.push_back(s_data);
        end
    endtask

    task automatic compare();
        chk("s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
        chk("wr_en",   32'(uart_wr_en), 32'(exp_wr));
        chk("data",    32'(uart_data_in), 32'(exp_data));
        chk("level",   32'(level), 32'(mq.size()));
        chk("empty",   32'(empty), 32'(mq.size() == 0));
        chk("full",    32'(full), 32'(mq.size() == DEPTH));
        chk("timeout", 32'(timeout), 32'(exp_to));
`ifdef UART_TX_FIFO_STATS_EN
        chk("frames_sent", 32'(frames_sent), 32'(exp_frames));
        chk("timeouts",    32'(timeouts), 32'(exp_tos));
`endif
    endtask

    task automatic respond();
        if (uart_wr_en === 1'b1 && alive) begin
            armed = 1'b1;
            pend  = int'($urandom_range(dly_max, dly_min));
            plen  = int'($urandom_range(len_max, len_min));
        end else if (armed) begin
            if (pend == 0) begin
                armed     = 1'b0;
                busy_left = plen;
            end else begin
                pend--;
            end
        end
        if (hold) begin
            uart_busy = 1'b1;
        end else if (busy_left > 0) begin
            uart_busy = 1'b1;
            busy_left--;
        end else begin
            uart_busy = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        if (uart_wr_en === 1'b1) got.push_back(uart_data_in);
        respond();
    endtask

    task automatic push_seq(input logic [7:0] b);
        s_valid = 1'b1;
        s_data  = b;
        tick();
    endtask

    initial begin
        logic [7:0] burst [4];
        int cnt;
        burst[0] = 8'hAB; burst[1] = 8'h55; burst[2] = 8'h00; burst[3] = 8'hFF;

        tick();
        tick();
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_level",   32'(level), 32'd0);
        chk("rst_empty",   32'(empty), 32'd1);
        chk("rst_full",    32'(full), 32'd0);
        chk("rst_wr_en",   32'(uart_wr_en), 32'd0);
        chk("rst_data",    32'(uart_data_in), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;

        // Single byte: launch one edge after the push edge.
        push_seq(8'hAB);
        s_valid = 1'b0;
        chk("t1_level_after_push", 32'(level), 32'd1);
        chk("t1_no_launch_yet", 32'(uart_wr_en), 32'd0);
        tick();
        chk("t1_launch", 32'(uart_wr_en), 32'd1);
        chk("t1_data", 32'(uart_data_in), 32'hAB);
        repeat (30) tick();

        // Back-to-back burst drains in order.
        got.delete();
        for (int i = 0; i < 4; i++) push_seq(burst[i]);
        s_valid = 1'b0;
        repeat (80) tick();
        chk("t2_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t2_order", 32'(got[i]), 32'(burst[i]));
        chk("t2_level", 32'(level), 32'd0);

        // Overfill while busy: the extra byte waits for the first pop.
        got.delete();
        hold = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) push_seq(8'(8'h10 + i));
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_s_ready", 32'(s_ready), 32'd0);
        s_data = 8'h99;
        tick();
        tick();
        chk("t3_extra_held", 32'(level), 32'(DEPTH));
        hold = 1'b0;
        for (int k = 0; k < 10 && uart_wr_en !== 1'b1; k++) tick();
        chk("t3_pop", 32'(uart_wr_en), 32'd1);
        chk("t3_level_pop", 32'(level), 32'(DEPTH - 1));
        chk("t3_ready_pop", 32'(s_ready), 32'd1);
        tick();
        chk("t3_extra_in", 32'(level), 32'(DEPTH));
        s_valid = 1'b0;
        repeat (100) tick();
        chk("t3_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t3_order", 32'(got[i]), 32'(8'h10 + i));
        if (got.size() == 5) chk("t3_extra_byte", 32'(got[4]), 32'h99);

        // Disconnected uart: timeout TMO cycles after the launch.
        alive = 1'b0;
        push_seq(8'h3C);
        s_valid = 1'b0;
        for (int k = 0; k < 10 && uart_wr_en !== 1'b1; k++) tick();
        chk("t4_launch", 32'(uart_wr_en), 32'd1);
        chk("t4_data", 32'(uart_data_in), 32'h3C);
        cnt = 0;
        for (int k = 0; k < 3 * TMO; k++) begin
            tick();
            cnt++;
            if (timeout === 1'b1) break;
        end
        chk("t4_timeout_delay", 32'(cnt), 32'(TMO));
        alive = 1'b1;
        repeat (5) tick();

        // Inter-frame gap: busy-low is seen one edge late, then GAP idle edges, then the launch edge.
        len_min = 3; len_max = 3;
        push_seq(8'hA1);
        push_seq(8'hA2);
        s_valid = 1'b0;
        for (int k = 0; k < 10 && uart_wr_en !== 1'b1; k++) tick();
        for (int k = 0; k < 10 && uart_busy !== 1'b1; k++) tick();
        for (int k = 0; k < 20 && uart_busy !== 1'b0; k++) tick();
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            cnt++;
            if (uart_wr_en === 1'b1) break;
        end
        chk("t5_gap_edges", 32'(cnt), 32'(GAP + 2));
        chk("t5_data", 32'(uart_data_in), 32'hA2);
        repeat (30) tick();

        // Reset mid-frame discards the queue.
        len_min = 20; len_max = 20;
        for (int i = 0; i < 4; i++) push_seq(8'(8'hC0 + i));
        s_valid = 1'b0;
        chk("t6_level_pre", 32'(level), 32'd3);
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
`ifdef UART_TX_FIFO_STATS_EN
        chk("t6_frames", 32'(frames_sent), 32'd0);
`endif
        got.delete();
        repeat (40) tick();
        chk("t6_no_launch", 32'(got.size()), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                dly_min = 0;
                dly_max = int'($urandom_range(TMO + 1, 0));
                len_min = 1;
                len_max = int'($urandom_range(8, 1));
                alive   = ($urandom_range(9, 0) != 0);
            end
            s_valid = ($urandom_range(99, 0) < 45);
            s_data  = 8'($urandom);
            rst     = ($urandom_range(799, 0) == 0);
            tick();
        end
        s_valid = 1'b0;
        rst = 1'b0;
        repeat (200) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
